// File: rtl/asyncio_transfer.sv
// asyncio_transfer: moves a block of 32-bit words between one selected stream
// port and a word-addressed memory port. Mode 0 pulls words from in_* and
// stores them; mode 1 loads words and pushes them out on out_*. One word is
// in flight at a time; done (and error for a bad port select) pulse once.
module asyncio_transfer #(
    parameter int ID_WIDTH      = 2,
    parameter int NO_OF_PORTS   = 4,
    parameter int ADDRESS_WIDTH = 32,
    parameter int LENGTH_WIDTH  = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       mode,
    input  logic [LENGTH_WIDTH-1:0]    length,
    input  logic [ADDRESS_WIDTH-1:0]   address,
    input  logic [ID_WIDTH-1:0]        io_id,
    input  logic [NO_OF_PORTS-1:0]     in_valid,
    input  logic [NO_OF_PORTS*32-1:0]  in_data,
    output logic [NO_OF_PORTS-1:0]     in_ready,
    output logic [NO_OF_PORTS-1:0]     out_valid,
    output logic [NO_OF_PORTS*32-1:0]  out_data,
    input  logic [NO_OF_PORTS-1:0]     out_ready,
    output logic                       memory_op_enable,
    output logic                       memory_op_write,
    input  logic                       memory_op_ready,
    output logic [31:0]                word_to_store,
    input  logic [31:0]                word_loaded,
    output logic [ADDRESS_WIDTH-1:0]   address_out,
    output logic [LENGTH_WIDTH-1:0]    length_out,
    output logic                       busy,
    output logic                       done,
    output logic                       error
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GET   = 3'd1;
    localparam logic [2:0] S_STORE = 3'd2;
    localparam logic [2:0] S_LOAD  = 3'd3;
    localparam logic [2:0] S_PUT   = 3'd4;

    localparam logic [ID_WIDTH:0] LP_PORTS = (ID_WIDTH+1)'(NO_OF_PORTS);

    logic [2:0]               r_state;
    logic [ID_WIDTH-1:0]      r_io_id;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [LENGTH_WIDTH-1:0]  r_len;
    logic [31:0]              r_word_store;
    logic [31:0]              r_word_load;
    logic                     r_done;
    logic                     r_error;

    logic [NO_OF_PORTS-1:0]   w_sel;
    logic [31:0]              w_in_data;
    logic                     w_in_valid;
    logic                     w_out_ready;
    logic                     w_bad_id;
    logic                     w_last;

    assign w_bad_id    = ({1'b0, io_id} >= LP_PORTS);
    assign w_last      = (r_len == LENGTH_WIDTH'(1));
    assign w_in_valid  = |(in_valid & w_sel);
    assign w_out_ready = |(out_ready & w_sel);

    // Decode the latched port select into a one-hot lane mask and pick its input word
    always_comb begin
        w_sel     = '0;
        w_in_data = '0;
        for (int unsigned i = 0; i < NO_OF_PORTS; i++) begin
            if (r_io_id == ID_WIDTH'(i)) begin
                w_sel[i]  = 1'b1;
                w_in_data = in_data[32*i +: 32];
            end
        end
    end

    // Transfer sequencer: command capture, stream/memory handshakes, counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_io_id      <= '0;
            r_addr       <= '0;
            r_len        <= '0;
            r_word_store <= '0;
            r_word_load  <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // Rejected commands leave the previous address/length visible.
                        if (w_bad_id) begin
                            r_done  <= 1'b1;
                            r_error <= 1'b1;
                        end else if (length == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_io_id <= io_id;
                            r_addr  <= address;
                            r_len   <= length;
                            r_state <= mode ? S_LOAD : S_GET;
                        end
                    end
                end
                S_GET: begin
                    if (w_in_valid) begin
                        r_word_store <= w_in_data;
                        r_state      <= S_STORE;
                    end
                end
                S_STORE: begin
                    if (memory_op_ready) begin
                        r_addr <= r_addr + ADDRESS_WIDTH'(4);
                        r_len  <= r_len - LENGTH_WIDTH'(1);
                        if (w_last) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_GET;
                        end
                    end
                end
                S_LOAD: begin
                    if (memory_op_ready) begin
                        r_word_load <= word_loaded;
                        r_state     <= S_PUT;
                    end
                end
                S_PUT: begin
                    if (w_out_ready) begin
                        r_addr <= r_addr + ADDRESS_WIDTH'(4);
                        r_len  <= r_len - LENGTH_WIDTH'(1);
                        if (w_last) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Stream-side outputs: only the selected lane is ever active, and only in GET/PUT
    always_comb begin
        in_ready  = '0;
        out_valid = '0;
        out_data  = '0;
        if (r_state == S_GET) begin
            in_ready = w_sel;
        end
        if (r_state == S_PUT) begin
            out_valid = w_sel;
            for (int unsigned i = 0; i < NO_OF_PORTS; i++) begin
                if (w_sel[i]) begin
                    out_data[32*i +: 32] = r_word_load;
                end
            end
        end
    end

    assign memory_op_enable = (r_state == S_STORE) || (r_state == S_LOAD);
    assign memory_op_write  = (r_state == S_STORE);
    assign word_to_store    = r_word_store;
    assign address_out      = r_addr;
    assign length_out       = r_len;
    assign busy             = (r_state != S_IDLE);
    assign done             = r_done;
    assign error            = r_error;

endmodule

// File: tb/tb_asyncio_transfer.sv
// Scoreboard bench for asyncio_transfer: commands push expected stores, stream
// words and done/error pulses into queues; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_asyncio_transfer;

    localparam int IDW = 3;
    localparam int NP  = 4;
    localparam int AW  = 32;
    localparam int LW  = 24;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            mode;
    logic [LW-1:0]   length;
    logic [AW-1:0]   address;
    logic [IDW-1:0]  io_id;
    logic [NP-1:0]   in_valid;
    logic [NP*32-1:0] in_data;
    logic [NP-1:0]   in_ready;
    logic [NP-1:0]   out_valid;
    logic [NP*32-1:0] out_data;
    logic [NP-1:0]   out_ready;
    logic            memory_op_enable;
    logic            memory_op_write;
    logic            memory_op_ready;
    logic [31:0]     word_to_store;
    logic [31:0]     word_loaded;
    logic [AW-1:0]   address_out;
    logic [LW-1:0]   length_out;
    logic            busy;
    logic            done;
    logic            error;

    asyncio_transfer #(
        .ID_WIDTH(IDW), .NO_OF_PORTS(NP), .ADDRESS_WIDTH(AW), .LENGTH_WIDTH(LW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .length(length),
        .address(address), .io_id(io_id), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .memory_op_enable(memory_op_enable),
        .memory_op_write(memory_op_write), .memory_op_ready(memory_op_ready),
        .word_to_store(word_to_store), .word_loaded(word_loaded),
        .address_out(address_out), .length_out(length_out), .busy(busy),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_st_addr[$];
    logic [31:0] exp_st_data[$];
    logic [31:0] src_q[$];
    logic [31:0] exp_out_data[$];
    int          exp_out_port[$];
    logic        exp_done_err[$];
    logic [31:0] mem_ovr[logic [31:0]];

    int src_port  = 0;
    bit stall     = 0;
    bit seq_data  = 0;
    bit hs_in     = 0;
    bit hs_mem_prev = 0;

    // Memory contents seen by loads: fixed overrides, else an address hash
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got an event, expected none", name);
    endtask

    // Monitor: compare every handshake and pulse against the queued expectations
    always @(negedge clk) begin
        logic [NP*32-1:0] idle_lanes;
        if (rst) begin
            hs_in       = 0;
            hs_mem_prev = 0;
        end else begin
            check("in_ready_lane", 64'(in_ready & ~(NP'(1) << src_port)), 0);
            check("out_valid_onehot", 64'($countones(out_valid) <= 1), 1);
            idle_lanes = '0;
            for (int i = 0; i < NP; i++)
                if (!out_valid[i]) idle_lanes[32*i +: 32] = out_data[32*i +: 32];
            check("idle_lanes_zero", 64'(|idle_lanes), 0);
            check("write_needs_enable", 64'(memory_op_write & ~memory_op_enable), 0);
            check("error_without_done", 64'(error & ~done), 0);
            if (hs_mem_prev) check("enable_drop", 64'(memory_op_enable), 0);

            if (memory_op_enable && memory_op_write && memory_op_ready) begin
                if (exp_st_addr.size() == 0) fail_event("unexpected_store");
                else begin
                    check("store_addr", 64'(address_out), 64'(exp_st_addr.pop_front()));
                    check("store_data", 64'(word_to_store), 64'(exp_st_data.pop_front()));
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (out_valid[p] && out_ready[p]) begin
                    if (exp_out_data.size() == 0) fail_event("unexpected_stream_out");
                    else begin
                        check("out_port", 64'(p), 64'(exp_out_port.pop_front()));
                        check("out_data", 64'(out_data[32*p +: 32]), 64'(exp_out_data.pop_front()));
                    end
                end
            end
            if (done) begin
                if (exp_done_err.size() == 0) fail_event("unexpected_done");
                else check("done_error", 64'(error), 64'(exp_done_err.pop_front()));
            end
            hs_in       = |(in_valid & in_ready);
            hs_mem_prev = memory_op_enable && memory_op_ready;
        end
    end

    // Environment: stream source, random sink readiness, random-latency memory
    always @(posedge clk) begin
        #1;
        if (hs_in && src_q.size() > 0) void'(src_q.pop_front());
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        in_valid = NP'($urandom) & ~(NP'(1) << src_port);
        if (!rst && !stall && src_q.size() > 0 && ($urandom % 4 != 0)) begin
            in_valid[src_port]         = 1'b1;
            in_data[32*src_port +: 32] = src_q[0];
        end
        out_ready       = NP'($urandom);
        memory_op_ready = 1'($urandom);
        word_loaded     = mem_word(address_out);
    end

    task automatic issue(input bit m, input int len, input logic [31:0] a, input int id);
        logic [31:0] w;
        if (id >= NP) exp_done_err.push_back(1'b1);
        else if (len == 0) exp_done_err.push_back(1'b0);
        else begin
            src_port = id;
            for (int k = 0; k < len; k++) begin
                if (!m) begin
                    w = seq_data ? 32'(k + 1) : $urandom;
                    src_q.push_back(w);
                    exp_st_addr.push_back(a + 32'(4 * k));
                    exp_st_data.push_back(w);
                end else begin
                    exp_out_port.push_back(id);
                    exp_out_data.push_back(mem_word(a + 32'(4 * k)));
                end
            end
            exp_done_err.push_back(1'b0);
        end
        start = 1'b1; mode = m; length = LW'(len); address = a; io_id = IDW'(id);
        @(negedge clk);
        start = 1'b0; mode = 1'($urandom); length = LW'($urandom);
        address = $urandom; io_id = IDW'($urandom);
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((busy || exp_done_err.size() != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (busy || exp_done_err.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: busy=%0d pending_done=%0d, required idle", name, busy, exp_done_err.size());
            exp_done_err.delete();
        end
        @(negedge clk);
        check({name, "_stores_left"}, 64'(exp_st_addr.size()), 0);
        check({name, "_outs_left"}, 64'(exp_out_data.size()), 0);
        exp_st_addr.delete(); exp_st_data.delete(); src_q.delete();
        exp_out_data.delete(); exp_out_port.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [AW-1:0] a0;
        logic [LW-1:0] l0;
        bit            m;
        int            len;
        int            id;
        logic [31:0]   a;

        rst = 1'b1; start = 1'b0; mode = 1'b0; length = '0; address = '0; io_id = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_error", 64'(error), 0);
        check("rst_enable", 64'(memory_op_enable), 0);
        check("rst_write", 64'(memory_op_write), 0);
        check("rst_in_ready", 64'(in_ready), 0);
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_out_data", 64'(|out_data), 0);
        check("rst_word_to_store", 64'(word_to_store), 0);
        check("rst_address_out", 64'(address_out), 0);
        check("rst_length_out", 64'(length_out), 0);
        rst = 1'b0;
        @(negedge clk);

        // Read 1..5 from port 0 into 4..20
        seq_data = 1;
        issue(0, 5, 32'h4, 0);
        wait_idle("read5");
        seq_data = 0;
        check("read5_length_out", 64'(length_out), 0);
        check("read5_address_out", 64'(address_out), 64'h18);

        // Write A,B,C from 0x100 out of port 3
        mem_ovr[32'h100] = 32'hA; mem_ovr[32'h104] = 32'hB; mem_ovr[32'h108] = 32'hC;
        issue(1, 3, 32'h100, 3);
        wait_idle("write3");
        check("write3_address_out", 64'(address_out), 64'h10C);

        // Stream stall mid-read: no store, counters frozen
        issue(0, 5, 32'h40, 2);
        t = 0;
        while (!(memory_op_enable && memory_op_write && length_out > 1) && t < 500) begin
            @(negedge clk); t++;
        end
        stall = 1;
        t = 0;
        while (!in_ready[2] && t < 500) begin
            @(negedge clk); t++;
        end
        a0 = address_out;
        l0 = length_out;
        check("stall_reached_get", 64'(in_ready), 64'h4);
        repeat (2) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'h4);
            check("stall_no_enable", 64'(memory_op_enable), 0);
            check("stall_address", 64'(address_out), 64'(a0));
            check("stall_length", 64'(length_out), 64'(l0));
        end
        stall = 0;
        wait_idle("stall");
        check("stall_address_out", 64'(address_out), 64'h54);

        // Zero length and bad port: immediate done, no traffic
        issue(0, 0, 32'h80, 1);
        check("zero_len_done", 64'(done), 1);
        check("zero_len_error", 64'(error), 0);
        repeat (3) begin
            check("zero_len_no_enable", 64'(memory_op_enable), 0);
            check("zero_len_idle", 64'(busy), 0);
            @(negedge clk);
        end
        issue(0, 3, 32'h80, NP);
        check("bad_id_done", 64'(done), 1);
        check("bad_id_error", 64'(error), 1);
        repeat (3) begin
            check("bad_id_no_enable", 64'(memory_op_enable), 0);
            check("bad_id_idle", 64'(busy), 0);
            @(negedge clk);
        end
        wait_idle("rejects");

        // Reset in STORE after two of five words
        issue(0, 5, 32'h200, 1);
        t = 0;
        while (!(memory_op_enable && memory_op_write && length_out == 3) && t < 500) begin
            @(negedge clk); t++;
        end
        check("abort_reached_store", 64'(length_out), 3);
        #1 rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 64'(busy), 0);
        check("abort_done", 64'(done), 0);
        check("abort_enable", 64'(memory_op_enable), 0);
        check("abort_write", 64'(memory_op_write), 0);
        check("abort_in_ready", 64'(in_ready), 0);
        check("abort_word_to_store", 64'(word_to_store), 0);
        check("abort_address_out", 64'(address_out), 0);
        check("abort_length_out", 64'(length_out), 0);
        exp_st_addr.delete(); exp_st_data.delete(); src_q.delete(); exp_done_err.delete();
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Start while busy with another port is ignored
        issue(1, 4, 32'h300, 2);
        repeat (3) @(negedge clk);
        check("busy_before_restart", 64'(busy), 1);
        start = 1'b1; mode = 1'b0; length = LW'(7); address = 32'h999; io_id = IDW'(0);
        @(negedge clk);
        start = 1'b0;
        wait_idle("ignore_start");
        check("ignore_start_address_out", 64'(address_out), 64'h310);
        check("ignore_start_length_out", 64'(length_out), 0);

        // Address wrap
        issue(0, 4, 32'hFFFF_FFF8, 1);
        wait_idle("wrap");
        check("wrap_address_out", 64'(address_out), 64'h8);

        // Random commands
        for (int n = 0; n < 25; n++) begin
            m   = 1'($urandom);
            len = $urandom_range(0, 6);
            id  = ($urandom % 8 == 0) ? 4 + ($urandom % 4) : ($urandom % 4);
            a   = $urandom & 32'hFFFF_FFFC;
            issue(m, len, a, id);
            wait_idle("random");
            if (id < NP && len > 0) begin
                check("random_length_out", 64'(length_out), 0);
                check("random_address_out", 64'(address_out), 64'(a + 32'(4 * len)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/asyncio_transfer.md
ASYNCIO_TRANSFER -- requirements
Module: asyncio_transfer

Interface
REQ-001 The block SHALL have parameter ID_WIDTH, default 2, width of the port-select field.
REQ-002 The block SHALL have parameter NO_OF_PORTS, default 4, number of stream ports per direction (at most 2**ID_WIDTH).
REQ-003 The block SHALL have parameter ADDRESS_WIDTH, default 32, byte-address width.
REQ-004 The block SHALL have parameter LENGTH_WIDTH, default 24, word-count width.
REQ-005 The block SHALL have these ports, each as name  direction  width  meaning:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command strobe, sampled in IDLE only.
- mode  in  1  0 = stream-to-memory (read), 1 = memory-to-stream (write).
- length  in  LENGTH_WIDTH  words to move.
- address  in  ADDRESS_WIDTH  first byte address, word aligned.
- io_id  in  ID_WIDTH  stream port select.
- in_valid  in  NO_OF_PORTS  per-port input valid.
- in_data  in  NO_OF_PORTS*32  port i at bits [32i+31:32i].
- in_ready  out  NO_OF_PORTS  per-port input ready.
- out_valid  out  NO_OF_PORTS  per-port output valid.
- out_data  out  NO_OF_PORTS*32  port i at bits [32i+31:32i].
- out_ready  in  NO_OF_PORTS  per-port output ready.
- memory_op_enable  out  1  memory request.
- memory_op_write  out  1  1 = store, 0 = load.
- memory_op_ready  in  1  request accepted this cycle (load data valid this cycle).
- word_to_store  out  32  store data.
- word_loaded  in  32  load data.
- address_out  out  ADDRESS_WIDTH  current word address.
- length_out  out  LENGTH_WIDTH  words remaining.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- error  out  1  one-cycle pulse with done on bad io_id.

Function
REQ-006 The FSM SHALL have states IDLE, GET (await stream word), STORE, LOAD, PUT (present stream word).
REQ-007 In IDLE with start=1: capture mode, address, io_id into registers, length_out<=length; next state GET (mode 0) or LOAD (mode 1).
REQ-008 If start=1 with length=0, the block SHALL stay in IDLE and pulse done next cycle, no memory or stream traffic.
REQ-009 If start=1 with io_id >= NO_OF_PORTS, the block SHALL stay in IDLE and pulse done and error together next cycle.
REQ-010 GET: in_ready[io_id]=1; on in_valid[io_id]=1 latch in_data word into word_to_store, go STORE.
REQ-011 STORE: memory_op_enable=1, memory_op_write=1; on memory_op_ready: address_out+=4, length_out-=1; then GET, or IDLE with done pulse if length_out was 1.
REQ-012 LOAD: memory_op_enable=1, memory_op_write=0; on memory_op_ready latch word_loaded, go PUT.
REQ-013 PUT: out_valid[io_id]=1 with latched word; on out_ready[io_id]: address_out+=4, length_out-=1; then LOAD, or IDLE with done pulse if length_out was 1.
REQ-014 Each stream and memory handshake SHALL transfer exactly one word; memory_op_enable SHALL drop in the cycle after acceptance.
REQ-015 All in_ready/out_valid bits other than io_id, and all out_data lanes other than io_id, SHALL be 0; selected out_data lane SHALL be 0 outside PUT.
REQ-016 start, length, address, io_id, mode SHALL be ignored while busy=1.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 address_out SHALL wrap modulo 2**ADDRESS_WIDTH; no error.

Reset
REQ-019 On rst=1 at a clock edge: state IDLE, busy/done/error/memory_op_enable/memory_op_write=0, in_ready/out_valid=0, word_to_store=0, address_out=0, length_out=0.
REQ-020 Reset mid-transfer SHALL abort with no done pulse; any latched word is discarded.

Verification
REQ-021 Read: io_id=0, address=4, length=5, port 0 sends 1..5, memory_op_ready toggled -> stores 1..5 at 4,8,12,16,20, one enable per word, done once, length_out=0.
REQ-022 Write: io_id=3, address=0x100, length=3, memory returns 0xA,0xB,0xC, out_ready low 2 cycles per word -> port 3 emits A,B,C in order, other out_valid bits 0.
REQ-023 in_valid[io_id] dropped 2 cycles mid-read -> no store issued while stalled, counts unchanged.
REQ-024 start with length=0 -> done=1 one cycle, error=0, no enable; start io_id=NO_OF_PORTS -> done=1, error=1.
REQ-025 rst asserted in STORE after 2 of 5 words -> next cycle all outputs at reset values, no done.
REQ-026 start pulsed while busy with different io_id -> ignored, original transfer completes unchanged.
